// File: rtl/mem_arbiter_if.sv
// Requester-side bus of the shared-memory arbiter: per-channel request/handshake
// signals packed by channel index, plus the shared read-data return.
interface mem_arbiter_if #(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_WIDTH  = 12,
  parameter int DATA_WIDTH  = 32
);
  logic [NUM_MASTERS-1:0]            m_req;
  logic [NUM_MASTERS-1:0]            m_write;
  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_addr;
  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_wdata;
  logic [NUM_MASTERS-1:0]            m_grant;
  logic [NUM_MASTERS-1:0]            m_done;
  logic [DATA_WIDTH-1:0]             m_rdata;

  modport master (
    output m_req, m_write, m_addr, m_wdata,
    input  m_grant, m_done, m_rdata
  );

  modport slave (
    input  m_req, m_write, m_addr, m_wdata,
    output m_grant, m_done, m_rdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// N-channel arbiter in front of a single-ported memory with configurable wait states.
// Define ARB_FIXED_PRIO_EN for lowest-index-wins arbitration instead of round-robin.
module mem_arbiter #(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_WIDTH  = 12,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  mem_arbiter_if.slave          bus,
  output logic                  MEM_enable,
  output logic                  MEM_read,
  output logic                  MEM_write,
  output logic [ADDR_WIDTH-1:0] MEM_address,
  output logic [DATA_WIDTH-1:0] MEM_in,
  input  logic [DATA_WIDTH-1:0] MEM_out,
  output logic                  busy
);

  localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] pick;
  logic             pick_valid;
  logic [3:0]       cnt;
`ifndef ARB_FIXED_PRIO_EN
  logic [IDX_W-1:0] rr_ptr;
`endif

  always_comb begin
    pick       = '0;
    pick_valid = 1'b0;
`ifdef ARB_FIXED_PRIO_EN
    for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
      if (bus.m_req[k]) begin
        pick       = IDX_W'(k);
        pick_valid = 1'b1;
      end
    end
`else
    // First requester at or above rr_ptr, wrapping back to channel 0
    for (int k = 0; k < NUM_MASTERS; k++) begin
      int j;
      j = (int'(rr_ptr) + k) % NUM_MASTERS;
      if (!pick_valid && bus.m_req[j]) begin
        pick       = IDX_W'(j);
        pick_valid = 1'b1;
      end
    end
`endif
  end

  // Grant is visible in the deciding IDLE cycle so a transaction takes MEM_LATENCY+2 cycles
  always_comb begin
    bus.m_grant = '0;
    if (rst && state == IDLE && pick_valid)
      bus.m_grant[pick] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      idx         <= '0;
      cnt         <= '0;
`ifndef ARB_FIXED_PRIO_EN
      rr_ptr      <= '0;
`endif
      MEM_enable  <= 1'b0;
      MEM_read    <= 1'b0;
      MEM_write   <= 1'b0;
      MEM_address <= '0;
      MEM_in      <= '0;
      busy        <= 1'b0;
      bus.m_done  <= '0;
      bus.m_rdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_valid) begin
            idx         <= pick;
            cnt         <= 4'(MEM_LATENCY - 1);
            MEM_enable  <= 1'b1;
            MEM_read    <= ~bus.m_write[pick];
            MEM_write   <= bus.m_write[pick];
            MEM_address <= bus.m_addr[pick*ADDR_WIDTH +: ADDR_WIDTH];
            MEM_in      <= bus.m_wdata[pick*DATA_WIDTH +: DATA_WIDTH];
            busy        <= 1'b1;
            state       <= ACCESS;
          end
        end
        ACCESS: begin
          if (cnt == 4'd0) begin
            if (MEM_read)
              bus.m_rdata <= MEM_out;
            MEM_enable      <= 1'b0;
            MEM_read        <= 1'b0;
            MEM_write       <= 1'b0;
            MEM_address     <= '0;
            MEM_in          <= '0;
            bus.m_done[idx] <= 1'b1;
            state           <= RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          bus.m_done <= '0;
          busy       <= 1'b0;
`ifndef ARB_FIXED_PRIO_EN
          rr_ptr     <= (idx == IDX_W'(NUM_MASTERS - 1)) ? '0 : idx + 1'b1;
`endif
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: a 2-channel/latency-1 and a 4-channel/latency-3
// instance, directed steps with a scoreboard of expected completions.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total  = 0;
  int passed = 0;
  int failed = 0;

  typedef struct {
    int          ch;
    logic [31:0] rdata;
  } exp_t;

  exp_t sb_a[$];
  exp_t sb_b[$];

  mem_arbiter_if #(.NUM_MASTERS(2), .ADDR_WIDTH(12), .DATA_WIDTH(32)) ifa ();
  mem_arbiter_if #(.NUM_MASTERS(4), .ADDR_WIDTH(12), .DATA_WIDTH(32)) ifb ();

  logic        mem_enable_a, mem_read_a, mem_write_a, busy_a;
  logic [11:0] mem_address_a;
  logic [31:0] mem_in_a, mem_out_a;
  logic        use_const_a = 1'b1;

  logic        mem_enable_b, mem_read_b, mem_write_b, busy_b;
  logic [11:0] mem_address_b;
  logic [31:0] mem_in_b, mem_out_b;

  // Memory models: data is derived from the address so each channel reads distinct data
  assign mem_out_a = use_const_a ? 32'hDEADBEEF : {20'hABCDE, mem_address_a};
  assign mem_out_b = {20'h5A5A5, mem_address_b};

  mem_arbiter #(.NUM_MASTERS(2), .ADDR_WIDTH(12), .DATA_WIDTH(32), .MEM_LATENCY(1)) dut_a (
    .clk(clk), .rst(rst), .bus(ifa),
    .MEM_enable(mem_enable_a), .MEM_read(mem_read_a), .MEM_write(mem_write_a),
    .MEM_address(mem_address_a), .MEM_in(mem_in_a), .MEM_out(mem_out_a), .busy(busy_a)
  );

  mem_arbiter #(.NUM_MASTERS(4), .ADDR_WIDTH(12), .DATA_WIDTH(32), .MEM_LATENCY(3)) dut_b (
    .clk(clk), .rst(rst), .bus(ifb),
    .MEM_enable(mem_enable_b), .MEM_read(mem_read_b), .MEM_write(mem_write_b),
    .MEM_address(mem_address_b), .MEM_in(mem_in_b), .MEM_out(mem_out_b), .busy(busy_b)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_grant_a(output logic [1:0] g);
    g = '0;
    for (int i = 0; i < 20; i++) begin
      if (ifa.m_grant != '0) begin
        g = ifa.m_grant;
        return;
      end
      @(negedge clk);
    end
  endtask

  task automatic wait_done_a(output logic [1:0] d);
    d = '0;
    for (int i = 0; i < 20; i++) begin
      if (ifa.m_done != '0) begin
        d = ifa.m_done;
        return;
      end
      @(negedge clk);
    end
  endtask

  task automatic wait_grant_b(output logic [3:0] g);
    g = '0;
    for (int i = 0; i < 20; i++) begin
      if (ifb.m_grant != '0) begin
        g = ifb.m_grant;
        return;
      end
      @(negedge clk);
    end
  endtask

  task automatic wait_done_b(output logic [3:0] d);
    d = '0;
    for (int i = 0; i < 20; i++) begin
      if (ifb.m_done != '0) begin
        d = ifb.m_done;
        return;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed simulation still running, expected finished");
    $fatal(1, "[TB] time limit reached");
  end

  initial begin
    logic [1:0]  ga, da;
    logic [3:0]  gb, db, dsum;
    int          t0, tg;
    exp_t        e;
    logic [31:0] last_rd_b;

    tg = 0;
    last_rd_b = '0;
    ifa.m_req = '0; ifa.m_write = '0; ifa.m_addr = '0; ifa.m_wdata = '0;
    ifb.m_req = '0; ifb.m_write = '0; ifb.m_addr = '0; ifb.m_wdata = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_busy_a", busy_a, 0);
    check("rst_enable_a", mem_enable_a, 0);
    check("rst_rdata_a", ifa.m_rdata, 0);
    check("rst_grant_b", ifb.m_grant, 0);
    check("rst_done_b", ifb.m_done, 0);
    check("rst_busy_b", busy_b, 0);
    rst = 1'b1;
    @(negedge clk);

    // Write on ch1 with three wait states
    ifb.m_req = 4'b0010; ifb.m_write = 4'b0010;
    ifb.m_addr[12 +: 12] = 12'h0FF; ifb.m_wdata[32 +: 32] = 32'h12345678;
    sb_b.push_back('{1, 32'h0});
    #1;
    check("wr_grant", ifb.m_grant, 4'b0010);
    t0 = cyc;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("wr_mem_bus", {busy_b, mem_enable_b, mem_write_b, mem_read_b, mem_address_b, mem_in_b},
            {1'b1, 1'b1, 1'b1, 1'b0, 12'h0FF, 32'h12345678});
    end
    @(negedge clk);
    wait_done_b(db);
    e = sb_b.pop_front();
    check("wr_done", db, 64'd1 << e.ch);
    check("wr_latency", cyc - t0, 4);
    check("wr_strobe_off", {mem_enable_b, mem_write_b}, 0);
    check("wr_rdata_kept", ifb.m_rdata, e.rdata);
    ifb.m_req = '0; ifb.m_write = '0;
    @(negedge clk);

    // ch1 and ch3 together right after ch1 finished
    ifb.m_addr[12 +: 12] = 12'h111; ifb.m_addr[36 +: 12] = 12'h333;
`ifdef ARB_FIXED_PRIO_EN
    sb_b.push_back('{1, 32'h5A5A5111});
    sb_b.push_back('{3, 32'h5A5A5333});
`else
    sb_b.push_back('{3, 32'h5A5A5333});
    sb_b.push_back('{1, 32'h5A5A5111});
`endif
    ifb.m_req = 4'b1010;
    #1;
    for (int t = 0; t < 2; t++) begin
      wait_grant_b(gb);
      check("rr_grant", gb, 64'd1 << sb_b[0].ch);
      @(negedge clk);
      wait_done_b(db);
      e = sb_b.pop_front();
      check("rr_done", db, 64'd1 << e.ch);
      check("rr_rdata", ifb.m_rdata, e.rdata);
      last_rd_b = e.rdata;
      ifb.m_req[e.ch] = 1'b0;
      @(negedge clk);
    end

    // Reset asserted in the second ACCESS cycle of a read
    ifb.m_addr[0 +: 12] = 12'h055; ifb.m_req = 4'b0001;
    #1;
    check("ra_grant", ifb.m_grant, 4'b0001);
    @(negedge clk);
    @(negedge clk);
    check("ra_rdata_held", ifb.m_rdata, last_rd_b);
    rst = 1'b0;
    #1;
    check("ra_enable", mem_enable_b, 0);
    check("ra_busy", busy_b, 0);
    check("ra_grant_off", ifb.m_grant, 0);
    ifb.m_req = '0;
    @(negedge clk);
    rst = 1'b1;
    dsum = '0;
    repeat (6) begin
      @(negedge clk);
      dsum |= ifb.m_done;
    end
    check("ra_no_done", dsum, 0);
    check("ra_idle", busy_b, 0);
    check("ra_rdata_clr", ifb.m_rdata, 0);

    // Both channels requesting continuously; ch0 drops out after four transactions
    use_const_a = 1'b0;
    ifa.m_addr = {12'h030, 12'h020}; ifa.m_write = '0;
`ifdef ARB_FIXED_PRIO_EN
    for (int t = 0; t < 4; t++) sb_a.push_back('{0, 32'hABCDE020});
`else
    for (int t = 0; t < 2; t++) begin
      sb_a.push_back('{0, 32'hABCDE020});
      sb_a.push_back('{1, 32'hABCDE030});
    end
`endif
    sb_a.push_back('{1, 32'hABCDE030});
    ifa.m_req = 2'b11;
    #1;
    for (int t = 0; t < 5; t++) begin
      wait_grant_a(ga);
      check("alt_grant", ga, 64'd1 << sb_a[0].ch);
      if (t > 0) check("alt_period", cyc - tg, 3);
      tg = cyc;
      @(negedge clk);
      wait_done_a(da);
      e = sb_a.pop_front();
      check("alt_done", da, 64'd1 << e.ch);
      check("alt_rdata", ifa.m_rdata, e.rdata);
      if (t == 3) ifa.m_req[0] = 1'b0;
      if (t == 4) ifa.m_req = '0;
      @(negedge clk);
    end

    // Single read on ch0 with one wait state
    use_const_a = 1'b1;
    ifa.m_addr[0 +: 12] = 12'h010;
    sb_a.push_back('{0, 32'hDEADBEEF});
    ifa.m_req = 2'b01;
    #1;
    check("rd_grant", ifa.m_grant, 2'b01);
    @(negedge clk);
    check("rd_mem_bus", {busy_a, mem_enable_a, mem_read_a, mem_write_a, mem_address_a},
          {1'b1, 1'b1, 1'b1, 1'b0, 12'h010});
    check("rd_grant_off", ifa.m_grant, 0);
    @(negedge clk);
    wait_done_a(da);
    e = sb_a.pop_front();
    check("rd_done", da, 64'd1 << e.ch);
    check("rd_rdata", ifa.m_rdata, e.rdata);
    check("rd_enable_off", mem_enable_a, 0);
    ifa.m_req = '0;
    @(negedge clk);
    check("rd_idle", busy_a, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
